// File: rtl/slc_datapath_p.sv
// SLC-3 datapath: PC/MAR/MDR/IR/LED/NZP/BEN registers, 8-entry register file,
// ALU, address adder and a one-hot gated internal bus with sticky contention flag.
module slc_datapath_p #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] PC_RESET = {DATA_W{1'b0}},
    parameter int                LED_W    = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        LD,
    input  logic [3:0]        GATE,
    input  logic              SR2MUX,
    input  logic              ADDR1MUX,
    input  logic [1:0]        ADDR2MUX,
    input  logic [1:0]        PCMUX,
    input  logic              DRMUX,
    input  logic              SR1MUX,
    input  logic [1:0]        ALUK,
    input  logic              MIO_EN,
    input  logic [DATA_W-1:0] MDR_In,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] PC,
    output logic [LED_W-1:0]  LED,
    output logic [2:0]        NZP,
    output logic              BEN,
    output logic              BUS_ERR
);

    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pc_r, mar_r, mdr_r, ir_r;
    logic [LED_W-1:0]  led_r;
    logic [2:0]        nzp_r;
    logic              ben_r;
    logic              bus_err_r;
    logic [DATA_W-1:0] regs_r [8];

    logic [2:0]        sr1_idx_s, dr_idx_s;
    logic [DATA_W-1:0] sr1_s, alu_b_s, alu_s;
    logic [DATA_W-1:0] addr1_s, addr2_s, addr_s;
    logic [DATA_W-1:0] bus_s, pc_next_s, mdr_next_s;
    logic              bus_multi_s;
    logic [2:0]        nzp_next_s;
    logic              ben_next_s;

    // Register-file read ports and ALU.
    always_comb begin
        sr1_idx_s = SR1MUX ? ir_r[8:6] : ir_r[11:9];
        dr_idx_s  = DRMUX ? 3'd7 : ir_r[11:9];
        sr1_s     = regs_r[sr1_idx_s];
        if (SR2MUX) begin
            alu_b_s = {{(DATA_W-5){ir_r[4]}}, ir_r[4:0]};
        end else begin
            alu_b_s = regs_r[ir_r[2:0]];
        end
        case (ALUK)
            2'b00:   alu_s = sr1_s + alu_b_s;
            2'b01:   alu_s = sr1_s & alu_b_s;
            2'b10:   alu_s = ~sr1_s;
            2'b11:   alu_s = sr1_s;
            default: alu_s = ZERO;
        endcase
    end

    // Address adder (MARMUX / branch target) and PC source selection.
    always_comb begin
        addr1_s = ADDR1MUX ? sr1_s : pc_r;
        case (ADDR2MUX)
            2'b00:   addr2_s = ZERO;
            2'b01:   addr2_s = {{(DATA_W-6){ir_r[5]}}, ir_r[5:0]};
            2'b10:   addr2_s = {{(DATA_W-9){ir_r[8]}}, ir_r[8:0]};
            2'b11:   addr2_s = {{(DATA_W-11){ir_r[10]}}, ir_r[10:0]};
            default: addr2_s = ZERO;
        endcase
        addr_s = addr1_s + addr2_s;
        case (PCMUX)
            2'b00:   pc_next_s = pc_r + ONE;
            2'b01:   pc_next_s = bus_s;
            2'b10:   pc_next_s = addr_s;
            2'b11:   pc_next_s = pc_r;
            default: pc_next_s = pc_r;
        endcase
    end

    // Internal bus: a legal gate pattern is one-hot or idle; anything else drives all ones.
    always_comb begin
        bus_multi_s = 1'b0;
        case (GATE)
            4'b0000: bus_s = ZERO;
            4'b1000: bus_s = pc_r;
            4'b0100: bus_s = mdr_r;
            4'b0010: bus_s = alu_s;
            4'b0001: bus_s = addr_s;
            default: begin
                bus_s       = ONES;
                bus_multi_s = 1'b1;
            end
        endcase
    end

    // Next values for MDR, condition codes and branch enable.
    always_comb begin
        mdr_next_s = MIO_EN ? MDR_In : bus_s;
        if (bus_s[DATA_W-1]) begin
            nzp_next_s = 3'b100;
        end else if (bus_s == ZERO) begin
            nzp_next_s = 3'b010;
        end else begin
            nzp_next_s = 3'b001;
        end
        ben_next_s = |(ir_r[11:9] & nzp_r);
    end

    // Architectural control/status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_r      <= PC_RESET;
            mar_r     <= ZERO;
            mdr_r     <= ZERO;
            ir_r      <= ZERO;
            led_r     <= {LED_W{1'b0}};
            nzp_r     <= 3'b000;
            ben_r     <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            if (LD[0]) mar_r <= bus_s;
            if (LD[1]) mdr_r <= mdr_next_s;
            if (LD[2]) ir_r  <= bus_s;
            if (LD[3]) ben_r <= ben_next_s;
            if (LD[4]) nzp_r <= nzp_next_s;
            if (LD[6]) pc_r  <= pc_next_s;
            if (LD[7]) led_r <= ir_r[LED_W-1:0];
            if (bus_multi_s) bus_err_r <= 1'b1;
        end
    end

    // General-purpose register file, single write port.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= ZERO;
            end
        end else if (LD[5]) begin
            regs_r[dr_idx_s] <= bus_s;
        end
    end

    assign MAR     = mar_r;
    assign MDR     = mdr_r;
    assign IR      = ir_r;
    assign PC      = pc_r;
    assign LED     = led_r;
    assign NZP     = nzp_r;
    assign BEN     = ben_r;
    assign BUS_ERR = bus_err_r;

endmodule
